// File: rtl/hilo_muldiv_pkg.sv
// Shared encodings and sign helpers for the HI/LO multiply/divide unit.
package hilo_muldiv_pkg;

  localparam logic [1:0] MD_MULT  = 2'b00;
  localparam logic [1:0] MD_MULTU = 2'b01;
  localparam logic [1:0] MD_DIV   = 2'b10;
  localparam logic [1:0] MD_DIVU  = 2'b11;

  localparam int unsigned MD_ITER = 32;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StMul  = 2'd1,
    StDiv  = 2'd2,
    StDone = 2'd3
  } md_state_e;

  function automatic logic [31:0] neg32(input logic [31:0] v, input logic en);
    return en ? (~v + 32'd1) : v;
  endfunction

  function automatic logic [63:0] neg64(input logic [63:0] v, input logic en);
    return en ? (~v + 64'd1) : v;
  endfunction

endpackage

// File: rtl/hilo_muldiv_div_core.sv
// Unsigned restoring divider (div_core): one quotient bit per cycle over MD_ITER cycles.
// done is high in the final iteration; quotient/remainder then carry that iteration's result.
module hilo_muldiv_div_core
  import hilo_muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        kill,
  input  logic        start,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  logic        busy_q, busy_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [63:0] rq_q, rq_d;
  logic [31:0] dvs_q, dvs_d;
  logic [32:0] trial;
  logic [63:0] step;

  // Upper half is the partial remainder, lower half shifts in quotient bits.
  always_comb begin
    trial = rq_q[63:31] - {1'b0, dvs_q};
    if (trial[32]) begin
      step = {rq_q[62:0], 1'b0};
    end else begin
      step = {trial[31:0], rq_q[30:0], 1'b1};
    end
  end

  assign done      = busy_q && (cnt_q == 5'(MD_ITER - 1));
  assign quotient  = step[31:0];
  assign remainder = step[63:32];

  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    rq_d   = rq_q;
    dvs_d  = dvs_q;
    if (start) begin
      busy_d = 1'b1;
      cnt_d  = '0;
      rq_d   = {32'd0, dividend};
      dvs_d  = divisor;
    end else if (busy_q) begin
      rq_d  = step;
      cnt_d = cnt_q + 5'd1;
      if (done) begin
        busy_d = 1'b0;
      end
    end
    if (kill) begin
      busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      rq_q   <= '0;
      dvs_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      rq_q   <= rq_d;
      dvs_q  <= dvs_d;
    end
  end

endmodule

// File: rtl/hilo_muldiv.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit producing the HI/LO register-file write port.
// Define HILO_ITER_MUL_EN for a 32-step shift-add multiplier instead of a 32x32 array.
module hilo_muldiv
  import hilo_muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  output logic        stall,
  output logic        hi_we,
  output logic        lo_we,
  output logic [31:0] hi_wdata,
  output logic [31:0] lo_wdata
);

  md_state_e   state_q, state_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic        neg_res_q, neg_res_d, neg_rem_q, neg_rem_d;
  logic        is_signed, is_div, div_zero, accept, div_go, div_done;
  logic [31:0] a_mag, b_mag, div_quo, div_rem;

  assign is_signed = (op == MD_MULT) || (op == MD_DIV);
  assign is_div    = (op == MD_DIV) || (op == MD_DIVU);
  assign div_zero  = is_div && (src_b == '0);
  assign accept    = start && !flush && (state_q == StIdle);
  assign div_go    = accept && is_div && !div_zero;
  assign a_mag     = neg32(src_a, is_signed & src_a[31]);
  assign b_mag     = neg32(src_b, is_signed & src_b[31]);

  hilo_muldiv_div_core u_div_core (
    .clk       (clk),
    .rst       (rst),
    .kill      (flush),
    .start     (div_go),
    .dividend  (a_mag),
    .divisor   (b_mag),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

`ifdef HILO_ITER_MUL_EN
  logic [31:0] mcand_q, mcand_d;
  logic [63:0] prod_q, prod_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [32:0] mul_sum;
  logic [63:0] mul_step;
  logic        mul_last;

  // Shift-add: HI half accumulates, LO half shifts the multiplier out LSB first.
  assign mul_sum  = {1'b0, prod_q[63:32]} + (prod_q[0] ? {1'b0, mcand_q} : 33'd0);
  assign mul_step = {mul_sum, prod_q[31:1]};
  assign mul_last = (state_q == StMul) && (cnt_q == 5'(MD_ITER - 1));
`else
  logic [63:0] prod_full;
  assign prod_full = {32'd0, a_mag} * {32'd0, b_mag};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (div_go) begin
            state_d = StDiv;
`ifdef HILO_ITER_MUL_EN
          end else if (!is_div) begin
            state_d = StMul;
`endif
          end else begin
            state_d = StDone;
          end
        end
      end
`ifdef HILO_ITER_MUL_EN
      StMul:   if (mul_last) state_d = StDone;
`endif
      StDiv:   if (div_done) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (flush) begin
      state_d = StIdle;
    end
  end

  always_comb begin
    stall = accept || (state_q == StMul) || (state_q == StDiv);
    hi_we = (state_q == StDone) && !flush;
    lo_we = hi_we;
  end

  always_comb begin
    hi_d      = hi_q;
    lo_d      = lo_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
`ifdef HILO_ITER_MUL_EN
    mcand_d = mcand_q;
    prod_d  = prod_q;
    cnt_d   = cnt_q;
    if (state_q == StMul) begin
      prod_d = mul_step;
      cnt_d  = cnt_q + 5'd1;
    end
    if (mul_last) begin
      {hi_d, lo_d} = neg64(mul_step, neg_res_q);
    end
`endif
    if (accept) begin
      neg_res_d = is_signed & (src_a[31] ^ src_b[31]);
      neg_rem_d = is_signed & src_a[31];
      if (div_zero) begin
        hi_d = src_a;
        lo_d = '1;
      end else if (!is_div) begin
`ifdef HILO_ITER_MUL_EN
        mcand_d = a_mag;
        prod_d  = {32'd0, b_mag};
        cnt_d   = '0;
`else
        {hi_d, lo_d} = neg64(prod_full, neg_res_d);
`endif
      end
    end
    if ((state_q == StDiv) && div_done) begin
      hi_d = neg32(div_rem, neg_rem_q);
      lo_d = neg32(div_quo, neg_res_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q      <= '0;
      lo_q      <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
`ifdef HILO_ITER_MUL_EN
      mcand_q   <= '0;
      prod_q    <= '0;
      cnt_q     <= '0;
`endif
    end else begin
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
`ifdef HILO_ITER_MUL_EN
      mcand_q   <= mcand_d;
      prod_q    <= prod_d;
      cnt_q     <= cnt_d;
`endif
    end
  end

  assign hi_wdata = hi_q;
  assign lo_wdata = lo_q;

endmodule

// File: tb/tb_hilo_muldiv.sv
// Directed bench for hilo_muldiv with a cycle-level arithmetic reference model.
module tb_hilo_muldiv;
  import hilo_muldiv_pkg::*;

`ifdef HILO_ITER_MUL_EN
  localparam int MLAT = 33;
`else
  localparam int MLAT = 1;
`endif

  logic        clk = 1'b0;
  logic        rst, flush, start;
  logic [1:0]  op;
  logic [31:0] src_a, src_b;
  logic        stall, hi_we, lo_we;
  logic [31:0] hi_wdata, lo_wdata;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  bit checking = 1'b0;

  hilo_muldiv dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .start    (start),
    .op       (op),
    .src_a    (src_a),
    .src_b    (src_b),
    .stall    (stall),
    .hi_we    (hi_we),
    .lo_we    (lo_we),
    .hi_wdata (hi_wdata),
    .lo_wdata (lo_wdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference results straight from integer arithmetic: {HI, LO}.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      MD_MULT:  res = 64'(sa * sb);
      MD_MULTU: res = {32'd0, a} * {32'd0, b};
      default: begin
        if (b == 32'd0) begin
          res = {a, 32'hFFFF_FFFF};
        end else if (o == MD_DIV) begin
          q = sa / sb;
          r = sa % sb;
          res = {r[31:0], q[31:0]};
        end else begin
          res = {a % b, a / b};
        end
      end
    endcase
    return res;
  endfunction

  function automatic int lat_of(input logic [1:0] o, input logic [31:0] b);
    if (o == MD_DIV || o == MD_DIVU) return (b == 32'd0) ? 1 : 33;
    return MLAT;
  endfunction

  // Every-cycle comparison against the model.
  initial begin : cmp
    bit          pend;
    bit          zchk;
    int          done_c;
    logic [63:0] exp;
    logic        es, ew;
    pend = 1'b0;
    zchk = 1'b1;
    done_c = 0;
    exp = '0;
    forever begin
      @(negedge clk);
      if (checking) begin
        es = pend ? (cyc < done_c) : (start && !flush);
        ew = pend && (cyc == done_c) && !flush;
        check("stall", {31'd0, stall}, {31'd0, es});
        check("hi_we", {31'd0, hi_we}, {31'd0, ew});
        check("lo_we", {31'd0, lo_we}, {31'd0, ew});
        if (ew) begin
          check("model_hi", hi_wdata, exp[63:32]);
          check("model_lo", lo_wdata, exp[31:0]);
        end
        if (zchk) begin
          check("reset_hi", hi_wdata, 32'd0);
          check("reset_lo", lo_wdata, 32'd0);
        end
        zchk = rst;
        if (rst || flush) begin
          pend = 1'b0;
        end else if (pend && cyc == done_c) begin
          pend = 1'b0;
        end else if (!pend && start) begin
          pend   = 1'b1;
          done_c = cyc + lat_of(op, src_b);
          exp    = model(op, src_a, src_b);
        end
      end
    end
  end

  task automatic wait_pulse(input string nm, input int c0, input int lat,
                            input logic [31:0] eh, input logic [31:0] el);
    do @(negedge clk); while (!hi_we && (cyc - c0) < 40);
    check({nm, "_seen"}, {31'd0, hi_we}, 32'd1);
    check({nm, "_lat"}, 32'(cyc - c0), 32'(lat));
    check({nm, "_hi"}, hi_wdata, eh);
    check({nm, "_lo"}, lo_wdata, el);
  endtask

  task automatic issue(input string nm, input logic [1:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                       input int lat);
    int c0;
    @(posedge clk); #1;
    start = 1'b1; op = o; src_a = a; src_b = b;
    c0 = cyc;
    @(posedge clk); #1;
    start = 1'b0; op = 2'($urandom); src_a = $urandom; src_b = $urandom;
    wait_pulse(nm, c0, lat, eh, el);
  endtask

  initial begin : drv
    int c0;
    rst = 1'b1; flush = 1'b0; start = 1'b0; op = '0; src_a = '0; src_b = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    checking = 1'b1;
    #1;
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_we", {31'd0, hi_we}, 32'd0);

    // DIVU 100/7 with a stray start mid-operation that must be ignored.
    @(posedge clk); #1;
    start = 1'b1; op = MD_DIVU; src_a = 32'd100; src_b = 32'd7;
    c0 = cyc;
    @(posedge clk); #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #1 start = 1'b1; op = MD_MULTU; src_a = 32'd3; src_b = 32'd3;
    @(posedge clk); #1 start = 1'b0;
    wait_pulse("divu_100_7", c0, 33, 32'd2, 32'd14);

    issue("div_m7_2",    MD_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 33);
    issue("mult_m1_2",   MD_MULT,  32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFE, MLAT);
    issue("multu_m1_2",  MD_MULTU, 32'hFFFF_FFFF, 32'd2,         32'd1,         32'hFFFF_FFFE, MLAT);
    issue("divu_5_0",    MD_DIVU,  32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF, 1);
    issue("div_ovf",     MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 33);
    issue("div_m7_0",    MD_DIV,   32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF, 1);
    issue("mult_min2",   MD_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0,         MLAT);
    issue("div_7_m2",    MD_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 33);
    issue("mult_neg",    MD_MULT,  32'd12345,     32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_6F55, MLAT);
    issue("divu_max_1",  MD_DIVU,  32'hFFFF_FFFF, 32'd1,         32'd0,         32'hFFFF_FFFF, 33);
    issue("divu_max_16", MD_DIVU,  32'hFFFF_FFFF, 32'h10,        32'hF,         32'h0FFF_FFFF, 33);

    // Flush in the DONE cycle suppresses the write.
    @(posedge clk); #1;
    start = 1'b1; op = MD_DIVU; src_a = 32'd5; src_b = 32'd0;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b1;
    #1 check("flush_done_we", {31'd0, hi_we}, 32'd0);
    @(posedge clk); #1 flush = 1'b0;
    repeat (2) @(posedge clk);

    // Flush in C10 of DIVU 100/7, then DIVU 9/4 issued in C11.
    #1 start = 1'b1; op = MD_DIVU; src_a = 32'd100; src_b = 32'd7;
    @(posedge clk); #1 start = 1'b0;
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    #1;
    check("flush_stall", {31'd0, stall}, 32'd0);
    check("flush_we", {31'd0, hi_we}, 32'd0);
    start = 1'b1; op = MD_DIVU; src_a = 32'd9; src_b = 32'd4;
    c0 = cyc;
    @(posedge clk); #1 start = 1'b0;
    wait_pulse("flush_next", c0, 33, 32'd1, 32'd2);

    // Reset in C20 of a DIV; start raised while reset is still held.
    @(posedge clk); #1;
    start = 1'b1; op = MD_DIV; src_a = 32'hFFFF_FF9C; src_b = 32'd7;
    @(posedge clk); #1 start = 1'b0;
    repeat (19) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    check("rst_mid_stall", {31'd0, stall}, 32'd0);
    check("rst_mid_we", {31'd0, hi_we}, 32'd0);
    check("rst_mid_hi", hi_wdata, 32'd0);
    check("rst_mid_lo", lo_wdata, 32'd0);
    start = 1'b1; op = MD_DIVU; src_a = 32'd9; src_b = 32'd4;
    @(posedge clk); #1 rst = 1'b0;
    c0 = cyc;
    @(posedge clk); #1 start = 1'b0;
    wait_pulse("rst_next", c0, 33, 32'd1, 32'd2);

    repeat (3) @(posedge clk);
    #1 $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
